// File: rtl/duv_out_monitor_if.sv
// Event port bundle for the DUV output monitor: lane inputs, capture enable,
// valid/ready event drain and status counters.
interface duv_out_monitor_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned LW    = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TSW   = 16
);
    logic                          en;
    logic [LANES*LW-1:0]           mon_in;
    logic                          ev_valid;
    logic                          ev_ready;
    logic [TSW+LANES+LANES*LW-1:0] ev_data;
    logic [$clog2(DEPTH+1)-1:0]    level;
    logic [7:0]                    drop_cnt;
    logic                          overflow;

    // master is the monitor itself; slave is the checker/trace consumer.
    modport master (
        input  en, mon_in, ev_ready,
        output ev_valid, ev_data, level, drop_cnt, overflow
    );

    modport slave (
        output en, mon_in, ev_ready,
        input  ev_valid, ev_data, level, drop_cnt, overflow
    );
endinterface

// File: rtl/duv_out_monitor.sv
// Samples the DUV output lanes every clock, records each change as a
// timestamped {ts, lane_mask, snapshot} event in a FWFT FIFO, counts drops.
module duv_out_monitor #(
    parameter int unsigned LANES = 4,
    parameter int unsigned LW    = 2,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TSW   = 16
) (
    input logic               clk,
    input logic               arst,
    duv_out_monitor_if.master bus
);
    localparam int unsigned SW  = LANES * LW;
    localparam int unsigned EW  = TSW + LANES + SW;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LVW = $clog2(DEPTH + 1);

    logic [SW-1:0]    prev_q;
    logic [TSW-1:0]   tick_q;
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LVW-1:0]   level_q;
    logic [7:0]       drop_cnt_q;
    logic             overflow_q;

    logic [LANES-1:0] lane_mask;
    logic             change;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             drop;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = bus.mon_in[i*LW +: LW] != prev_q[i*LW +: LW];
        end
        change = bus.en && (bus.mon_in != prev_q);
        full   = (level_q == LVW'(DEPTH));
        empty  = (level_q == '0);
        pop    = !empty && bus.ev_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push   = change && (!full || pop);
        drop   = change && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            prev_q     <= '0;
            tick_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q <= bus.mon_in;
            tick_q <= tick_q + TSW'(1);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (!arst && push) begin
            mem_q[wr_ptr_q] <= {tick_q, lane_mask, bus.mon_in};
        end
    end

    assign bus.ev_valid = !empty;
    assign bus.ev_data  = mem_q[rd_ptr_q];
    assign bus.level    = level_q;
    assign bus.drop_cnt = drop_cnt_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_duv_out_monitor.sv
// Self-checking bench for duv_out_monitor: vector table plus hand sequences,
// with an event scoreboard compared on every pop.
module tb_duv_out_monitor;
    logic clk;
    logic arst;
    logic arst2;

    duv_out_monitor_if #(.LANES(4), .LW(2), .DEPTH(16), .TSW(16)) bus ();
    duv_out_monitor_if #(.LANES(4), .LW(2), .DEPTH(4),  .TSW(4))  bus2 ();

    duv_out_monitor #(.LANES(4), .LW(2), .DEPTH(16), .TSW(16)) u_dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    duv_out_monitor #(.LANES(4), .LW(2), .DEPTH(4), .TSW(4)) u_dut_wrap (
        .clk  (clk),
        .arst (arst2),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       e;
        logic [7:0] m;
        logic       r;
        logic       v;
        logic [4:0] l;
    } vec_t;

    vec_t        vecs[$];
    logic [27:0] sb[$];
    logic [7:0]  tb_prev;
    logic [15:0] tb_tick;
    int          n_total;
    int          n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [4:0] l,
                           input logic [7:0] d, input logic o);
        chk({name, "_valid"}, 32'(bus.ev_valid), 32'(v));
        chk({name, "_level"}, 32'(bus.level), 32'(l));
        chk({name, "_drop"}, 32'(bus.drop_cnt), 32'(d));
        chk({name, "_ovf"}, 32'(bus.overflow), 32'(o));
    endtask

    // Drive one edge; pushes the expected event and scores any pop on this edge.
    task automatic step(input logic a, input logic e, input logic [7:0] m, input logic r);
        logic [3:0] msk;
        logic       pop;
        logic       full;
        arst         = a;
        bus.en       = e;
        bus.mon_in   = m;
        bus.ev_ready = r;
        full = (sb.size() == 16);
        pop  = !a && (bus.ev_valid === 1'b1) && r;
        if (pop) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'(bus.ev_data), 32'hFFFF_FFFF);
            end else begin
                chk("ev_data", 32'(bus.ev_data), 32'(sb.pop_front()));
            end
        end
        for (int i = 0; i < 4; i++) begin
            msk[i] = m[i*2 +: 2] != tb_prev[i*2 +: 2];
        end
        if (a) begin
            sb.delete();
            tb_prev = '0;
            tb_tick = '0;
        end else begin
            if (e && (m != tb_prev) && (!full || pop)) begin
                sb.push_back({tb_tick, msk, m});
            end
            tb_prev = m;
            tb_tick = tb_tick + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic e, input logic [7:0] m, input logic r);
        bus2.en       = e;
        bus2.mon_in   = m;
        bus2.ev_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        tb_prev = '0;
        tb_tick = '0;
        arst2         = 1'b1;
        bus2.en       = 1'b0;
        bus2.mon_in   = '0;
        bus2.ev_ready = 1'b0;

        // Reset, driver-like sequence, multi-lane change and enable gating.
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 5'd0});
        vecs.push_back('{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 5'd0});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 5'd1});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 5'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0});
        for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0});
        vecs.push_back('{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 5'd1});
        vecs.push_back('{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 5'd1});
        vecs.push_back('{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 5'd0});
        vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0});
        for (int i = 0; i < 7; i++) vecs.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd0});
        vecs.push_back('{1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 5'd1});
        vecs.push_back('{1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 5'd0});
        vecs.push_back('{1'b0, 1'b0, 8'h30, 1'b1, 1'b0, 5'd0});
        vecs.push_back('{1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 5'd0});
        vecs.push_back('{1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 5'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].a, vecs[i].e, vecs[i].m, vecs[i].r);
            chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].l, 8'd0, 1'b0);
        end
        // Independent of the bench tick: the spec-fixed events of the sequences above.
        chk("sb_empty_after_vecs", 32'(sb.size()), 32'd0);

        // Overflow: 18 changes into a stalled 16-deep FIFO.
        step(1'b1, 1'b1, 8'h00, 1'b0);
        chk_out("ovf_reset", 1'b0, 5'd0, 8'd0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
        end
        chk_out("ovf_full", 1'b1, 5'd16, 8'd2, 1'b1);
        chk("ovf_head_ts0", 32'(bus.ev_data), {4'h0, 16'd0, 4'h1, 8'h01});
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
        chk_out("ovf_drained", 1'b0, 5'd0, 8'd2, 1'b1);
        chk("sb_empty_after_ovf", 32'(sb.size()), 32'd0);

        // Full FIFO with a pop and a push on the same edge.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h00, 1'b0);
        end
        chk_out("full_again", 1'b1, 5'd16, 8'd2, 1'b1);
        step(1'b0, 1'b1, 8'h01, 1'b1);
        chk_out("full_pushpop", 1'b1, 5'd16, 8'd2, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h01, 1'b1);
        chk_out("full_drained", 1'b0, 5'd0, 8'd2, 1'b1);
        chk("sb_empty_after_full", 32'(sb.size()), 32'd0);

        // Reset while nine events are pending; the change on the reset edge is discarded.
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0) ? 8'h00 : 8'h01, 1'b0);
        end
        chk_out("mid_level9", 1'b1, 5'd9, 8'd2, 1'b1);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        chk_out("mid_reset", 1'b0, 5'd0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk_out("mid_after", 1'b0, 5'd0, 8'd0, 1'b0);

        // Timestamp wrap on the 4-bit tick instance.
        step2(1'b1, 8'h00, 1'b0);
        arst2 = 1'b0;
        for (int i = 0; i < 15; i++) step2(1'b1, 8'h00, 1'b0);
        chk("wrap_idle_valid", 32'(bus2.ev_valid), 32'd0);
        step2(1'b1, 8'h01, 1'b0);
        step2(1'b1, 8'h00, 1'b0);
        chk("wrap_level", 32'(bus2.level), 32'd2);
        chk("wrap_ev_ts15", 32'(bus2.ev_data), {4'hF, 4'h1, 8'h01});
        step2(1'b1, 8'h00, 1'b1);
        chk("wrap_ev_ts0", 32'(bus2.ev_data), {4'h0, 4'h1, 8'h00});
        chk("wrap_level_pop", 32'(bus2.level), 32'd1);
        step2(1'b1, 8'h00, 1'b1);
        chk("wrap_empty", 32'(bus2.ev_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
